// File: rtl/freq_meter_pkg.sv
// Shared state encoding, default parameters and BCD helpers for freq_meter.
package freq_meter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_GATE = 1'b1
    } state_e;

    localparam int unsigned DEF_GATE_CYCLES = 50_000_000;
    localparam int unsigned DEF_GATE_W      = 26;
    localparam int unsigned DEF_FREQ_W      = 26;
    localparam int unsigned DEF_DIGITS      = 8;
    localparam int unsigned BCD_DIGIT_W     = 4;

    // Double-dabble correction applied to a digit before each shift.
    function automatic logic [BCD_DIGIT_W-1:0] bcd_add3(input logic [BCD_DIGIT_W-1:0] d);
        return (d >= BCD_DIGIT_W'(5)) ? d + BCD_DIGIT_W'(3) : d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter: one bit per cycle, done pulse
// with the held result after BIN_W iterations.
module bin2bcd_seq
    import freq_meter_pkg::*;
#(
    parameter int unsigned BIN_W  = DEF_FREQ_W,
    parameter int unsigned DIGITS = DEF_DIGITS
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            start_i,
    input  logic [BIN_W-1:0]                bin_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic [BCD_DIGIT_W*DIGITS-1:0]   bcd_o
);

    localparam int unsigned BcdW = BCD_DIGIT_W * DIGITS;
    localparam int unsigned CntW = $clog2(BIN_W + 1);

    logic [BIN_W-1:0] bin_q;
    logic [BcdW-1:0]  acc_q, acc_adj, acc_d, bcd_q;
    logic [CntW-1:0]  cnt_q;
    logic             busy_q, done_q;

    always_comb begin
        acc_adj = acc_q;
        for (int d = 0; d < int'(DIGITS); d++) begin
            acc_adj[d*BCD_DIGIT_W +: BCD_DIGIT_W] = bcd_add3(acc_q[d*BCD_DIGIT_W +: BCD_DIGIT_W]);
        end
        acc_d = {acc_adj[BcdW-2:0], bin_q[BIN_W-1]};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            bin_q  <= '0;
            acc_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i && !busy_q) begin
                bin_q  <= bin_i;
                acc_q  <= '0;
                cnt_q  <= '0;
                busy_q <= 1'b1;
            end else if (busy_q) begin
                acc_q <= acc_d;
                bin_q <= bin_q << 1;
                cnt_q <= cnt_q + CntW'(1);
                if (cnt_q == CntW'(BIN_W - 1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    bcd_q  <= acc_d;
                end
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/freq_meter.sv
// Gated rising-edge frequency counter with held result and one-cycle valid strobe.
// Define FREQ_METER_BCD_EN to add the sequential BCD readout (Bcd_Out / Bcd_Valid).
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int unsigned GATE_W      = DEF_GATE_W,
    parameter int unsigned FREQ_W      = DEF_FREQ_W,
    parameter int unsigned DIGITS      = DEF_DIGITS
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            En,
    input  logic                            Sig_In,
    output logic [FREQ_W-1:0]               Freq_Out,
    output logic                            Valid,
    output logic                            Ovf,
`ifdef FREQ_METER_BCD_EN
    output logic [BCD_DIGIT_W*DIGITS-1:0]   Bcd_Out,
    output logic                            Bcd_Valid,
`endif
    output logic                            Busy
);

    if (GATE_CYCLES < 64 || (longint'(1) << GATE_W) < longint'(GATE_CYCLES) ||
        DIGITS == 0) begin : g_param_err
        $error("freq_meter: illegal GATE_CYCLES/GATE_W/DIGITS combination");
    end

    state_e            state_q;
    logic [2:0]        sync_q;
    logic [GATE_W-1:0] gate_cnt_q;
    logic [FREQ_W-1:0] edge_cnt_q, edge_inc, freq_q;
    logic              sat_q, ovf_q, valid_q;
    logic              rise, rise_sat, last_cycle;

    // sync_q[0..2] are the s1/s2/s3 stages; Sig_In is asynchronous to CLK.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], Sig_In};
        end
    end

    assign rise       = sync_q[1] & ~sync_q[2];
    assign rise_sat   = rise & (&edge_cnt_q);
    assign edge_inc   = rise_sat ? edge_cnt_q : edge_cnt_q + FREQ_W'(rise);
    assign last_cycle = (gate_cnt_q == GATE_W'(GATE_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            freq_q     <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    gate_cnt_q <= '0;
                    edge_cnt_q <= '0;
                    sat_q      <= 1'b0;
                    if (En) state_q <= ST_GATE;
                end
                ST_GATE: begin
                    if (!En) begin
                        state_q    <= ST_IDLE;
                        gate_cnt_q <= '0;
                        edge_cnt_q <= '0;
                        sat_q      <= 1'b0;
                    end else if (last_cycle) begin
                        // Final-cycle edge belongs to this window; next window starts now.
                        freq_q     <= edge_inc;
                        ovf_q      <= sat_q | rise_sat;
                        valid_q    <= 1'b1;
                        gate_cnt_q <= '0;
                        edge_cnt_q <= '0;
                        sat_q      <= 1'b0;
                    end else begin
                        gate_cnt_q <= gate_cnt_q + GATE_W'(1);
                        edge_cnt_q <= edge_inc;
                        sat_q      <= sat_q | rise_sat;
                    end
                end
            endcase
        end
    end

    assign Freq_Out = freq_q;
    assign Ovf      = ovf_q;
    assign Valid    = valid_q;
    assign Busy     = (state_q == ST_GATE);

`ifdef FREQ_METER_BCD_EN
    logic bcd_busy;

    bin2bcd_seq #(
        .BIN_W  (FREQ_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .start_i (valid_q & ~bcd_busy),
        .bin_i   (freq_q),
        .busy_o  (bcd_busy),
        .done_o  (Bcd_Valid),
        .bcd_o   (Bcd_Out)
    );
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: two instances (wide and 4-bit result) share stimulus
// and are scored every cycle against a window-level counting model.
module tb_freq_meter;

    localparam int GC = 100;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic En = 1'b0;
    logic Sig_In = 1'b0;

    logic [25:0] fo0;
    logic [3:0]  fo1;
    logic        v0, v1, o0, o1, b0, b1;
`ifdef FREQ_METER_BCD_EN
    logic [31:0] bcd0, bcd1;
    logic        bv0, bv1;
`endif

    always #5 CLK = ~CLK;

    freq_meter #(.GATE_CYCLES(GC), .GATE_W(7), .FREQ_W(26), .DIGITS(8)) dut (
        .CLK(CLK), .RST(RST), .En(En), .Sig_In(Sig_In),
        .Freq_Out(fo0), .Valid(v0), .Ovf(o0),
`ifdef FREQ_METER_BCD_EN
        .Bcd_Out(bcd0), .Bcd_Valid(bv0),
`endif
        .Busy(b0)
    );

    freq_meter #(.GATE_CYCLES(GC), .GATE_W(7), .FREQ_W(4), .DIGITS(8)) dut_s (
        .CLK(CLK), .RST(RST), .En(En), .Sig_In(Sig_In),
        .Freq_Out(fo1), .Valid(v1), .Ovf(o1),
`ifdef FREQ_METER_BCD_EN
        .Bcd_Out(bcd1), .Bcd_Valid(bv1),
`endif
        .Busy(b1)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    // Waveform generator: fixed high/low phase lengths or random (2..7 cycles).
    int wave_hi = 5, wave_lo = 5, gen_left = 0;
    bit wave_rnd = 0;

    // Reference model: input samples delayed for the 3-cycle sync latency, unbounded
    // per-window edge count, saturated only when published.
    bit h1 = 0, h2 = 0, h3 = 0;
    bit m_active[2], m_valid[2], m_ovf[2];
    int m_pos[2], m_cnt[2], m_freq[2];
    int maxv[2] = '{67108863, 15};
`ifdef FREQ_METER_BCD_EN
    int bcd_cd[2] = '{-1, -1};
    int bcd_lat[2] = '{27, 5};
    logic [31:0] bcd_pend[2], bcd_exp[2];
`endif

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        r = '0;
        for (int d = 0; d < 8; d++) begin
            r[d*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic set_wave(input int hi, input int lo, input bit rnd);
        wave_hi = hi;
        wave_lo = lo;
        wave_rnd = rnd;
    endtask

    task automatic tick();
        int rise;
        int a_fo, a_v, a_o, a_b;
        if (gen_left == 0) begin
            Sig_In = ~Sig_In;
            gen_left = wave_rnd ? int'($urandom_range(2, 7)) : (Sig_In ? wave_hi : wave_lo);
        end
        gen_left--;
        @(posedge CLK);
        rise = (h2 && !h3) ? 1 : 0;
        if (!RST) begin
            h1 = 0; h2 = 0; h3 = 0;
        end else begin
            h3 = h2; h2 = h1; h1 = Sig_In;
        end
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 0;
            if (!RST) begin
                m_active[i] = 0; m_pos[i] = 0; m_cnt[i] = 0; m_freq[i] = 0; m_ovf[i] = 0;
            end else if (!m_active[i]) begin
                if (En) begin
                    m_active[i] = 1; m_pos[i] = 0; m_cnt[i] = 0;
                end
            end else if (!En) begin
                m_active[i] = 0;
            end else begin
                m_cnt[i] += rise;
                if (m_pos[i] == GC - 1) begin
                    m_freq[i] = (m_cnt[i] > maxv[i]) ? maxv[i] : m_cnt[i];
                    m_ovf[i] = (m_cnt[i] > maxv[i]);
                    m_valid[i] = 1;
                    m_pos[i] = 0;
                    m_cnt[i] = 0;
                end else begin
                    m_pos[i]++;
                end
            end
        end
        cyc++;
        @(negedge CLK);
        for (int i = 0; i < 2; i++) begin
            a_fo = (i == 0) ? int'(fo0) : int'(fo1);
            a_v  = (i == 0) ? int'(v0) : int'(v1);
            a_o  = (i == 0) ? int'(o0) : int'(o1);
            a_b  = (i == 0) ? int'(b0) : int'(b1);
            n_cmp += 4;
            if (a_fo !== m_freq[i]) begin
                n_err++;
                $display("FAIL freq_out[%0d] cycle %0d: got %0d expected %0d", i, cyc, a_fo, m_freq[i]);
            end
            if (a_v !== int'(m_valid[i])) begin
                n_err++;
                $display("FAIL valid[%0d] cycle %0d: got %0d expected %0d", i, cyc, a_v, m_valid[i]);
            end
            if (a_o !== int'(m_ovf[i])) begin
                n_err++;
                $display("FAIL ovf[%0d] cycle %0d: got %0d expected %0d", i, cyc, a_o, m_ovf[i]);
            end
            if (a_b !== int'(m_active[i])) begin
                n_err++;
                $display("FAIL busy[%0d] cycle %0d: got %0d expected %0d", i, cyc, a_b, m_active[i]);
            end
`ifdef FREQ_METER_BCD_EN
            begin
                bit e_bv;
                logic [31:0] a_bcd;
                logic a_bv;
                e_bv = 0;
                if (!RST) begin
                    bcd_cd[i] = -1;
                    bcd_exp[i] = '0;
                end else begin
                    if (bcd_cd[i] > 0) bcd_cd[i]--;
                    if (bcd_cd[i] == 0) begin
                        e_bv = 1;
                        bcd_exp[i] = bcd_pend[i];
                        bcd_cd[i] = -1;
                    end
                    if (m_valid[i]) begin
                        bcd_cd[i] = bcd_lat[i];
                        bcd_pend[i] = to_bcd(m_freq[i]);
                    end
                end
                a_bcd = (i == 0) ? bcd0 : bcd1;
                a_bv  = (i == 0) ? bv0 : bv1;
                n_cmp += 2;
                if (a_bv !== e_bv) begin
                    n_err++;
                    $display("FAIL bcd_valid[%0d] cycle %0d: got %0d expected %0d", i, cyc, a_bv, e_bv);
                end
                if (a_bcd !== bcd_exp[i]) begin
                    n_err++;
                    $display("FAIL bcd_out[%0d] cycle %0d: got %h expected %h", i, cyc, a_bcd, bcd_exp[i]);
                end
            end
`endif
        end
    endtask

    // Ticks until the wide DUT raises Valid; n = cycles taken, or -1 if the bound expires.
    task automatic steps_to_valid(input int bound, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!v0 && n < bound);
        if (!v0) n = -1;
    endtask

    task automatic wait_model_valid(input int k);
        for (int j = 0; j < k; j++) begin
            int c;
            c = 0;
            do begin
                tick();
                c++;
            end while (!m_valid[0] && c < 300);
            n_cmp++;
            if (!m_valid[0]) begin
                n_err++;
                $display("FAIL wait_window: no window end within 300 cycles, expected one");
            end
        end
    endtask

    task automatic test_reset();
        RST = 0;
        En = 0;
        repeat (3) tick();
        n_cmp += 4;
        if (fo0 !== 26'd0) begin n_err++; $display("FAIL reset_freq: got %0d expected 0", fo0); end
        if (v0 !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0d expected 0", v0); end
        if (o0 !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %0d expected 0", o0); end
        if (b0 !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0d expected 0", b0); end
        RST = 1;
    endtask

    task automatic test_period10();
        int n;
        set_wave(5, 5, 0);
        En = 1;
        repeat (250) tick();
        steps_to_valid(150, n);
        steps_to_valid(150, n);
        n_cmp += 3;
        if (n != 100) begin n_err++; $display("FAIL p10_valid_period: got %0d expected 100", n); end
        if (fo0 !== 26'd10) begin n_err++; $display("FAIL p10_freq: got %0d expected 10", fo0); end
        if (o0 !== 1'b0) begin n_err++; $display("FAIL p10_ovf: got %0d expected 0", o0); end
        tick();
        n_cmp++;
        if (v0 !== 1'b0) begin n_err++; $display("FAIL p10_valid_width: got %0d expected 0", v0); end
    endtask

    task automatic test_period4();
        int n, sum;
        set_wave(2, 2, 0);
        wait_model_valid(3);
        sum = 0;
        for (int w = 0; w < 5; w++) begin
            steps_to_valid(150, n);
            n_cmp++;
            if (n != 100) begin n_err++; $display("FAIL p4_valid_period: got %0d expected 100", n); end
            sum += int'(fo0);
        end
        n_cmp += 3;
        if (sum != 125) begin n_err++; $display("FAIL p4_window_sum: got %0d expected 125", sum); end
        if (fo1 !== 4'd15) begin n_err++; $display("FAIL sat_freq: got %0d expected 15", fo1); end
        if (o1 !== 1'b1) begin n_err++; $display("FAIL sat_ovf: got %0d expected 1", o1); end
    endtask

    task automatic test_sat_recover();
        set_wave(10, 10, 0);
        wait_model_valid(3);
        n_cmp += 3;
        if (fo1 !== 4'd5) begin n_err++; $display("FAIL recover_freq: got %0d expected 5", fo1); end
        if (o1 !== 1'b0) begin n_err++; $display("FAIL recover_ovf: got %0d expected 0", o1); end
        if (fo0 !== 26'd5) begin n_err++; $display("FAIL p20_freq: got %0d expected 5", fo0); end
    endtask

    task automatic test_en_drop();
        int n, seen;
        set_wave(5, 5, 0);
        wait_model_valid(3);
        n_cmp++;
        if (fo0 !== 26'd10) begin n_err++; $display("FAIL drop_pre_freq: got %0d expected 10", fo0); end
        repeat (50) tick();
        En = 0;
        seen = 0;
        repeat (120) begin
            tick();
            if (v0) seen++;
        end
        n_cmp += 3;
        if (seen != 0) begin n_err++; $display("FAIL drop_no_valid: got %0d strobes expected 0", seen); end
        if (fo0 !== 26'd10) begin n_err++; $display("FAIL drop_hold_freq: got %0d expected 10", fo0); end
        if (b0 !== 1'b0) begin n_err++; $display("FAIL drop_busy: got %0d expected 0", b0); end
        En = 1;
        steps_to_valid(200, n);
        n_cmp += 2;
        if (n != 101) begin n_err++; $display("FAIL reenable_latency: got %0d expected 101", n); end
        if (fo0 !== 26'd10) begin n_err++; $display("FAIL reenable_freq: got %0d expected 10", fo0); end
    endtask

    task automatic test_reset_mid();
        int n;
        repeat (30) tick();
        RST = 0;
        tick();
        n_cmp += 4;
        if (fo0 !== 26'd0) begin n_err++; $display("FAIL midrst_freq: got %0d expected 0", fo0); end
        if (v0 !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %0d expected 0", v0); end
        if (o0 !== 1'b0) begin n_err++; $display("FAIL midrst_ovf: got %0d expected 0", o0); end
        if (b0 !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %0d expected 0", b0); end
        RST = 1;
        steps_to_valid(200, n);
        n_cmp++;
        if (n != 101) begin n_err++; $display("FAIL midrst_restart: got %0d expected 101", n); end
    endtask

    task automatic test_random();
        set_wave(0, 0, 1);
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 249) == 0) En = ~En;
            RST = ($urandom_range(0, 799) == 0) ? 1'b0 : 1'b1;
            tick();
        end
        RST = 1;
        En = 1;
        repeat (5) tick();
    endtask

    initial begin
        test_reset();
        test_period10();
        test_period4();
        test_sat_recover();
        test_en_drop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
